// File: rtl/ifu_fetch_queue_pkg.sv
// ifu_pkg: shared response codes, entry layout and default widths for the fetch unit
package ifu_pkg;
    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;
    typedef struct packed {
        logic [DW_DEF-1:0] inst;
        logic [AW_DEF-1:0] pc;
        logic              err;
    } fetch_entry_t;
endpackage

// File: rtl/ifu_fetch_queue_sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous clear; a push on full is legal only alongside a pop
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, wr_q;
    logic [CW-1:0]    cnt_q;
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= (wr_q == LAST) ? '0 : wr_q + 1'b1;
            if (pop_i) rd_q <= (rd_q == LAST) ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: AXI4-Lite instruction fetch with credit-limited outstanding reads and a flushable queue
module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int DEPTH     = 4,
    parameter int MAX_OUTST = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_next,
    input  logic          ifu_receive_valid,
    output logic          ifu_receive_ready,
    input  logic          flush,
    output logic          ifu_send_valid,
    input  logic          ifu_send_ready,
    output logic [DW-1:0] instruction,
    output logic [AW-1:0] inst_pc,
    output logic          inst_err,
    output logic [AW-1:0] araddr,
    output logic          arvalid,
    input  logic          arready,
    input  logic [DW-1:0] rdata,
    input  logic [1:0]    rresp,
    input  logic          rvalid,
    output logic          rready
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PCW = $clog2(MAX_OUTST + 1);
    localparam int QW = DW + AW + 1;
    localparam logic [CW:0] CRED_MAX = DEPTH[CW:0];
    localparam logic [CW-1:0] OUTST_MAX = MAX_OUTST[CW-1:0];
    logic [CW-1:0]  inflight_q, inflight_d, drop_q, drop_d, qcnt;
    logic [CW:0]    credits;
    logic [PCW-1:0] pc_cnt;
    logic [AW-1:0]  araddr_q, beat_pc;
    logic           arvalid_q, rready_q, accept, r_beat, keep, pop, err;
    logic [QW-1:0]  q_din, q_dout;
    assign credits = {1'b0, qcnt} + {1'b0, inflight_q};
    assign ifu_receive_ready = !flush && (!arvalid_q || arready) && credits < CRED_MAX && inflight_q < OUTST_MAX;
    assign accept = ifu_receive_valid && ifu_receive_ready;
    assign r_beat = rvalid && rready_q;
    // beats belonging to flushed fetches are swallowed until drop_q runs out
    assign keep = r_beat && drop_q == '0 && !flush && pc_cnt != '0;
    assign pop = ifu_send_valid && ifu_send_ready && !flush;
    assign err = resp_e'(rresp) != OKAY;
    assign inflight_d = inflight_q + CW'(accept) - CW'(r_beat);
    assign drop_d = flush ? inflight_q - CW'(r_beat) : (r_beat && drop_q != '0) ? drop_q - CW'(1) : drop_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            rready_q   <= 1'b0;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            arvalid_q  <= accept || (arvalid_q && !arready);
            araddr_q   <= accept ? pc_next : araddr_q;
            rready_q   <= 1'b1;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end
    sync_fifo #(.WIDTH(AW), .DEPTH(MAX_OUTST)) u_pc_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .push_i  (accept),
        .pop_i   (keep),
        .din_i   (pc_next),
        .dout_o  (beat_pc),
        .count_o (pc_cnt)
    );
    assign q_din = {err ? '0 : rdata, beat_pc, err};
    sync_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_inst_q (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .push_i  (keep),
        .pop_i   (pop),
        .din_i   (q_din),
        .dout_o  (q_dout),
        .count_o (qcnt)
    );
    assign ifu_send_valid = qcnt != '0;
    assign {instruction, inst_pc, inst_err} = q_dout;
    assign araddr = araddr_q;
    assign arvalid = arvalid_q;
    assign rready = rready_q;
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// tb_ifu_fetch_queue: directed and randomized checks of ifu_fetch_queue against a transaction-level model
module tb_ifu_fetch_queue;
    import ifu_pkg::*;
    localparam int DEPTH = 4;
    localparam int MAX_OUTST = 2;
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] pc_next = '0, rdata = '0, instruction, inst_pc, araddr;
    logic        ifu_receive_valid = 1'b0, ifu_receive_ready, flush = 1'b0;
    logic        ifu_send_valid, ifu_send_ready = 1'b0, inst_err;
    logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
    logic [1:0]  rresp = 2'b00;
    always #5 clk = ~clk;
    ifu_fetch_queue #(.AW(32), .DW(32), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
        .clk               (clk),
        .rst               (rst),
        .pc_next           (pc_next),
        .ifu_receive_valid (ifu_receive_valid),
        .ifu_receive_ready (ifu_receive_ready),
        .flush             (flush),
        .ifu_send_valid    (ifu_send_valid),
        .ifu_send_ready    (ifu_send_ready),
        .instruction       (instruction),
        .inst_pc           (inst_pc),
        .inst_err          (inst_err),
        .araddr            (araddr),
        .arvalid           (arvalid),
        .arready           (arready),
        .rdata             (rdata),
        .rresp             (rresp),
        .rvalid            (rvalid),
        .rready            (rready)
    );
    typedef struct {
        logic [31:0] pc;
        int          ep;
        int          due;
    } fetch_t;
    fetch_t      ar_exp[$], rq[$];
    logic [31:0] exp_q[$];
    int          n_chk = 0, n_fail = 0;
    int          cyc = 0, epoch = 0, inflight = 0, q_occ = 0;
    int          n_req = 0, n_acc = 0, n_pop = 0, n_err = 0;
    int          rv_p = 100, sr_p = 100, ar_p = 100, fl_pm = 0, lat_lo = 1, lat_hi = 1;
    bit          fl_req = 0, rst_req = 1, post_rst = 0, prev_acc = 0, prev_stall = 0;
    logic [31:0] prev_pc = '0, prev_addr = '0, next_pc = 32'h8000_0000, last_pc = '0, last_inst = '0;
    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return pc ^ 32'h8000_0413;
    endfunction
    function automatic logic is_err(input logic [31:0] pc);
        return pc[5:2] == 4'd1;
    endfunction
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    task automatic step();
        fetch_t      f;
        logic [31:0] e, hp;
        bit          acc, ar_hs, r_hs, pop, m_arv, rdy_exp;
        @(negedge clk);
        rst = rst_req;
        pc_next = next_pc;
        ifu_receive_valid = !rst_req && n_req > 0 && int'($urandom_range(99)) < rv_p;
        ifu_send_ready = int'($urandom_range(99)) < sr_p;
        arready = int'($urandom_range(99)) < ar_p;
        flush = !rst_req && (fl_req || int'($urandom_range(999)) < fl_pm);
        rvalid = 1'b0;
        rdata = $urandom;
        rresp = OKAY;
        if (!rst_req && rq.size() > 0) begin
            if (cyc >= rq[0].due) begin
                hp = rq[0].pc;
                rvalid = 1'b1;
                rdata = mem_word(hp);
                rresp = is_err(hp) ? (hp[6] ? DECERR : SLVERR) : OKAY;
            end
        end
        #1;
        if (rst_req) begin
            exp_q.delete();
            ar_exp.delete();
            rq.delete();
            inflight = 0;
            q_occ = 0;
            epoch++;
            prev_acc = 0;
            prev_stall = 0;
            post_rst = 1;
        end else begin
            m_arv = prev_acc || prev_stall;
            if (post_rst) begin
                check("rst_araddr", araddr, 0);
                check("rst_rready", rready, 0);
            end else check("rready", rready, 1);
            check("send_valid", ifu_send_valid, q_occ != 0);
            check("arvalid", arvalid, m_arv);
            if (m_arv) check("araddr_hold", araddr, prev_acc ? prev_pc : prev_addr);
            rdy_exp = !flush && (!m_arv || arready) && (q_occ + inflight) < DEPTH && inflight < MAX_OUTST;
            check("recv_ready", ifu_receive_ready, rdy_exp);
            acc = ifu_receive_valid && ifu_receive_ready;
            ar_hs = arvalid && arready;
            r_hs = rvalid && rready;
            pop = ifu_send_valid && ifu_send_ready && !flush;
            if (pop) begin
                check("pop_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("inst_pc", inst_pc, e);
                    check("instruction", instruction, is_err(e) ? 32'h0 : mem_word(e));
                    check("inst_err", inst_err, is_err(e));
                    last_pc = inst_pc;
                    last_inst = instruction;
                    n_pop++;
                    if (inst_err) n_err++;
                end
            end
            if (ar_hs) begin
                check("ar_pending", ar_exp.size() > 0, 1);
                if (ar_exp.size() > 0) begin
                    f = ar_exp.pop_front();
                    check("ar_order", araddr, f.pc);
                    f.due = cyc + int'($urandom_range(lat_hi, lat_lo));
                    rq.push_back(f);
                end
            end
            if (r_hs) begin
                f = rq.pop_front();
                inflight--;
                if (f.ep == epoch && !flush) q_occ++;
            end
            if (acc) begin
                inflight++;
                n_req--;
                n_acc++;
                f.pc = next_pc;
                f.ep = epoch;
                f.due = 0;
                ar_exp.push_back(f);
                exp_q.push_back(next_pc);
            end
            if (pop) q_occ--;
            if (flush) begin
                exp_q.delete();
                q_occ = 0;
                epoch++;
            end
            check("outstanding", inflight <= MAX_OUTST, 1);
            prev_stall = arvalid && !arready;
            prev_addr = araddr;
            prev_acc = acc;
            prev_pc = next_pc;
            if (acc) next_pc += 32'd4;
            post_rst = 0;
        end
        cyc++;
    endtask
    initial begin
        int b, a, er;
        repeat (2) step();
        rst_req = 0;
        step();
        n_req = 1;
        b = n_pop;
        repeat (8) step();
        check("t1_pops", n_pop - b, 1);
        check("t1_pc", last_pc, 32'h8000_0000);
        check("t1_inst", last_inst, 32'h0000_0413);
        next_pc = 32'h8000_0000;
        n_req = 8;
        sr_p = 0;
        lat_lo = 3;
        lat_hi = 3;
        a = n_acc;
        repeat (16) step();
        check("t2_accepted", n_acc - a, DEPTH);
        check("t2_ready_low", ifu_receive_ready, 0);
        sr_p = 100;
        b = n_pop;
        repeat (30) step();
        check("t2_drained", n_pop - b, 8);
        check("t2_last_pc", last_pc, 32'h8000_001c);
        ar_p = 0;
        n_req = 2;
        repeat (6) step();
        check("t3_arvalid_held", arvalid, 1);
        check("t3_ready_low", ifu_receive_ready, 0);
        ar_p = 100;
        repeat (12) step();
        next_pc = 32'h8000_0040;
        n_req = 2;
        lat_lo = 6;
        lat_hi = 6;
        repeat (3) step();
        fl_req = 1;
        step();
        fl_req = 0;
        next_pc = 32'h8000_0100;
        n_req = 1;
        lat_lo = 1;
        lat_hi = 2;
        b = n_pop;
        repeat (20) step();
        check("t4_pops", n_pop - b, 1);
        check("t4_pc", last_pc, 32'h8000_0100);
        next_pc = 32'h8000_0004;
        n_req = 2;
        b = n_pop;
        er = n_err;
        repeat (12) step();
        check("t5_pops", n_pop - b, 2);
        check("t5_errs", n_err - er, 1);
        check("t5_last_pc", last_pc, 32'h8000_0008);
        check("t5_last_inst", last_inst, mem_word(32'h8000_0008));
        sr_p = 0;
        n_req = 20;
        repeat (12) step();
        check("t6_full", ifu_send_valid, 1);
        n_req = 0;
        rst_req = 1;
        step();
        rst_req = 0;
        step();
        sr_p = 100;
        n_req = 1_000_000;
        for (int ph = 0; ph < 30; ph++) begin
            rv_p = $urandom_range(100, 20);
            sr_p = $urandom_range(100, 10);
            ar_p = $urandom_range(100, 20);
            fl_pm = $urandom_range(40);
            lat_hi = $urandom_range(5, 1);
            if ($urandom_range(3) == 0) next_pc = $urandom & 32'hffff_fffc;
            if (ph == 15) begin
                rst_req = 1;
                step();
                rst_req = 0;
            end
            repeat (100) step();
        end
        n_req = 0;
        fl_pm = 0;
        sr_p = 100;
        ar_p = 100;
        for (int i = 0; i < 200 && (exp_q.size() > 0 || inflight > 0); i++) step();
        check("drain_queue", exp_q.size(), 0);
        check("drain_inflight", inflight, 0);
        step();
        check("drain_send_valid", ifu_send_valid, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
